// File: rtl/bus_pkg.sv
// Shared definitions for the two-master split-capable bus arbiter.
package bus_pkg;

  localparam int NUM_SLAVES_DEF = 3;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_OWN    = 2'd1;
  localparam logic [1:0] ST_RETURN = 2'd2;

  localparam logic M1 = 1'b0;
  localparam logic M2 = 1'b1;

endpackage

// File: rtl/arb_timer.sv
// Ownership timer: counts bus-owned cycles and flags the final allowed cycle.
module arb_timer #(
  parameter int TIMEOUT = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int W = $clog2(TIMEOUT + 1);

  logic [W-1:0] countQ;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      countQ <= '0;
    end else if (enable) begin
      countQ <= countQ + 1'b1;
    end
  end

  // Asserted on the edge that would close the TIMEOUT-th owned cycle.
  assign expired = enable && (countQ == W'(TIMEOUT - 1));

endmodule

// File: rtl/bus_arbiter.sv
// Two-master bus arbiter with alternating priority, ownership timeout and
// split-read handling (park the reader while its slave holds, return later).
module bus_arbiter
  import bus_pkg::*;
#(
  parameter int NUM_SLAVES = NUM_SLAVES_DEF,
  parameter int TIMEOUT    = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_m1,
  input  logic                  req_m2,
  input  logic [1:0]            sel_m1,
  input  logic [1:0]            sel_m2,
  input  logic [NUM_SLAVES-1:0] slave_hold,
  output logic                  grant_m1,
  output logic                  grant_m2,
  output logic [NUM_SLAVES-1:0] bus_available,
  output logic                  split_pending,
  output logic                  timeout_pulse
);

  logic [1:0] stateQ, stateD;
  logic       ownerQ, ownerD;
  logic [1:0] selQ, selD;
  logic       lastOwnerQ, lastOwnerD;
  logic       splitPendingQ, splitPendingD;
  logic       splitMasterQ, splitMasterD;
  logic [1:0] splitSlaveQ, splitSlaveD;
  logic       grantM1Q, grantM2Q;
  logic       timeoutPulseQ, timeoutPulseD;

  logic busy, ownerReq, ownHold, splitHold, elig1, elig2, win, expired;

  assign busy     = (stateQ != ST_IDLE);
  assign ownerReq = (ownerQ == M1) ? req_m1 : req_m2;

  // A master is eligible only with an in-range target and not parked on a split.
  assign elig1 = req_m1 && (int'(sel_m1) < NUM_SLAVES) && !(splitPendingQ && splitMasterQ == M1);
  assign elig2 = req_m2 && (int'(sel_m2) < NUM_SLAVES) && !(splitPendingQ && splitMasterQ == M2);

  always_comb begin
    ownHold   = 1'b0;
    splitHold = 1'b0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (i == int'(selQ))        ownHold   = slave_hold[i];
      if (i == int'(splitSlaveQ)) splitHold = slave_hold[i];
    end
  end

  arb_timer #(
    .TIMEOUT(TIMEOUT)
  ) uTimer (
    .clk    (clk),
    .rst    (rst),
    .clear  (!busy),
    .enable (busy),
    .expired(expired)
  );

  always_comb begin
    stateD        = stateQ;
    ownerD        = ownerQ;
    selD          = selQ;
    lastOwnerD    = lastOwnerQ;
    splitPendingD = splitPendingQ;
    splitMasterD  = splitMasterQ;
    splitSlaveD   = splitSlaveQ;
    timeoutPulseD = 1'b0;
    win           = M1;
    unique case (stateQ)
      ST_IDLE: begin
        // Returning a split read outranks any fresh request.
        if (splitPendingQ && !splitHold) begin
          stateD        = ST_RETURN;
          ownerD        = splitMasterQ;
          selD          = splitSlaveQ;
          lastOwnerD    = splitMasterQ;
          splitPendingD = 1'b0;
        end else if (elig1 || elig2) begin
          win        = (elig1 && elig2) ? ~lastOwnerQ : (elig1 ? M1 : M2);
          stateD     = ST_OWN;
          ownerD     = win;
          selD       = (win == M1) ? sel_m1 : sel_m2;
          lastOwnerD = win;
        end
      end
      ST_OWN, ST_RETURN: begin
        if (!ownerReq) begin
          stateD = ST_IDLE;
        end else if (expired) begin
          stateD        = ST_IDLE;
          timeoutPulseD = 1'b1;
        end else if (ownHold && !splitPendingQ) begin
          stateD        = ST_IDLE;
          splitPendingD = 1'b1;
          splitMasterD  = ownerQ;
          splitSlaveD   = selQ;
        end else begin
          stateD = ST_OWN;
        end
      end
      default: stateD = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stateQ        <= ST_IDLE;
      ownerQ        <= M1;
      selQ          <= 2'd0;
      lastOwnerQ    <= M2;
      splitPendingQ <= 1'b0;
      splitMasterQ  <= M1;
      splitSlaveQ   <= 2'd0;
      grantM1Q      <= 1'b0;
      grantM2Q      <= 1'b0;
      timeoutPulseQ <= 1'b0;
    end else begin
      stateQ        <= stateD;
      ownerQ        <= ownerD;
      selQ          <= selD;
      lastOwnerQ    <= lastOwnerD;
      splitPendingQ <= splitPendingD;
      splitMasterQ  <= splitMasterD;
      splitSlaveQ   <= splitSlaveD;
      grantM1Q      <= (stateD != ST_IDLE) && (ownerD == M1);
      grantM2Q      <= (stateD != ST_IDLE) && (ownerD == M2);
      timeoutPulseQ <= timeoutPulseD;
    end
  end

  always_comb begin
    bus_available = '0;
    if (!busy) begin
      bus_available = '1;
    end else begin
      for (int i = 0; i < NUM_SLAVES; i++) begin
        bus_available[i] = (i == int'(selQ));
      end
    end
  end

  assign grant_m1      = grantM1Q;
  assign grant_m2      = grantM2Q;
  assign split_pending = splitPendingQ;
  assign timeout_pulse = timeoutPulseQ;

endmodule

// File: doc/bus_arbiter.md
BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 Parameter NUM_SLAVES, default 3: number of serial slaves on the shared bus.
REQ-002 Parameter TIMEOUT, default 64: maximum cycles one master may own the bus.
REQ-003 clk  in  1  single clock; all logic updates on its rising edge.
REQ-004 rst  in  1  reset; synchronous, active-high.
REQ-005 req_m1, req_m2  in  1 each  bus request; held high for the whole transaction.
REQ-006 sel_m1, sel_m2  in  2 each  target slave index, valid while the matching req is high.
REQ-007 slave_hold  in  NUM_SLAVES  per-slave hold (read-wait) indication.
REQ-008 grant_m1, grant_m2  out  1 each  registered bus grant, one-hot or zero.
REQ-009 bus_available  out  NUM_SLAVES  per-slave permission to drive read data.
REQ-010 split_pending  out  1  a split read is outstanding.
REQ-011 timeout_pulse  out  1  one-cycle pulse on a forced release.

Function
REQ-012 States SHALL be IDLE, OWN, RETURN; the FSM SHALL be registered, with next-state logic combinational.
REQ-013 IDLE: all grants low; bus_available SHALL be high for every slave.
REQ-014 IDLE->OWN when any eligible req is high at edge n; the grant SHALL be high from edge n+1, and the owner and sel SHALL be latched at that edge.
REQ-015 Simultaneous requests: the master that was not last_owner SHALL win; last_owner SHALL update on every grant.
REQ-016 OWN: bus_available SHALL be high only at the latched slave index.
REQ-017 OWN->IDLE when the owner's req is low at edge n; the grant SHALL be low at edge n+1, with at least one IDLE cycle before any new grant.
REQ-018 The timeout counter SHALL clear on grant and increment each OWN cycle; on reaching TIMEOUT, the FSM SHALL go OWN->IDLE and timeout_pulse SHALL be high for exactly 1 cycle.
REQ-019 Split: in OWN, if slave_hold of the latched slave is high and split_pending=0, the arbiter SHALL record split_master/split_slave, set split_pending, drop the grant and go to IDLE.
REQ-020 While split_pending=1, the split master SHALL be ineligible; the other master MAY own the bus.
REQ-021 While split_pending=1, a hold from the current owner's slave SHALL NOT cause a second split; that owner SHALL keep the grant until release or timeout.
REQ-022 IDLE->RETURN when split_pending=1 and slave_hold[split_slave]=0; RETURN SHALL take priority over new requests arriving in the same cycle.
REQ-023 RETURN: grant the split master, with bus_available high only at split_slave, and clear split_pending; RETURN SHALL then behave as OWN, including release, timeout and the same latched slave.
REQ-024 An out-of-range sel (>= NUM_SLAVES) SHALL be refused: no grant, request ignored.
REQ-025 A split master dropping req before RETURN SHALL still receive RETURN; the arbiter SHALL exit to IDLE the next cycle because req is low.

Reset
REQ-026 With rst high at an edge, the arbiter SHALL enter IDLE, drive all grants 0, timeout_pulse 0 and split_pending 0, and set the counter to 0 and last_owner to M2, so M1 wins first.
REQ-027 Reset mid-transaction or mid-split SHALL drop grants at that edge and discard split state; bus_available SHALL then be all-ones (IDLE).

Structure
REQ-028 The shared package bus_pkg SHALL hold the state encoding, master IDs (M1, M2) and the NUM_SLAVES default.
REQ-029 The timeout counter SHALL be a sub-module named arb_timer (clear, enable, expired).

Verification
REQ-030 Reset, then req_m1=1, sel_m1=2 -> grant_m1=1 after 1 cycle, bus_available=3'b100; drop req -> grant 0 next cycle.
REQ-031 req_m1 and req_m2 rise together twice in succession -> M1 is granted first, then M2 after the IDLE gap.
REQ-032 M1 holds req for 70 cycles with TIMEOUT=64 -> grant drops after 64 OWN cycles, timeout_pulse high for 1 cycle.
REQ-033 M1 reads slave 0 and slave_hold[0] rises -> split_pending=1 and grant_m1=0; M2 then owns slave 1; hold falls while M2 owns -> RETURN only after M2 releases, with grant_m1=1 and bus_available=3'b001.
REQ-034 Split pending and a hold from slave 1 during M2 ownership -> no second split; grant_m2 stays high.
REQ-035 rst pulsed during RETURN -> grants 0, split_pending 0 and bus_available=3'b111 at the next edge.
